// File: rtl/weight_update_pp.sv
// weight_update_pp: ping-pong weight buffer between the weight loader and the PE-array prefetcher.
// Define WEIGHT_UPDATE_PP_ZERO_FLAG_EN to add per-PE all-zero flags aligned with weight_pref.
module weight_update_pp #(
    parameter int N    = 16,
    parameter int ROWS = 4,
    parameter int COLS = 8,
    parameter int WG   = 3,
    parameter int RW   = ($clog2(ROWS) > 0 ? $clog2(ROWS) : 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       w_in_valid,
    output logic                       w_in_ready,
    input  logic [COLS*WG*N-1:0]       w_in_data,
    input  logic                       bcast,
    input  logic                       flush,
    input  logic                       swap,
    output logic                       shadow_full,
    output logic [RW-1:0]              load_row,
    output logic                       swap_done,
    output logic [ROWS*COLS*WG*N-1:0]  weight_pref
`ifdef WEIGHT_UPDATE_PP_ZERO_FLAG_EN
    ,
    output logic [ROWS*COLS-1:0]       zero_flag
`endif
);

    localparam int ROW_W = COLS*WG*N;
    localparam int PE_W  = WG*N;

    typedef enum logic {
        S_LOAD = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [RW-1:0]               r_load_row;
    logic [RW-1:0]               w_load_row_nxt;
    logic                        r_shadow_full;
    logic                        r_swap_done;
    logic [ROW_W-1:0]            r_shadow [ROWS];
    logic [ROWS*COLS*WG*N-1:0]   r_active;
    logic                        w_accept;
    logic                        w_swap;
    logic                        w_last_row;

    // flush outranks both swap and a beat presented in the same cycle
    assign w_in_ready = (r_state == S_LOAD);
    assign w_swap     = swap && (r_state == S_FULL) && !flush;
    assign w_accept   = w_in_valid && w_in_ready && !flush;
    assign w_last_row = (r_load_row == RW'(ROWS-1));

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        w_state_nxt    = r_state;
        w_load_row_nxt = r_load_row;
        if (flush || w_swap) begin
            w_state_nxt    = S_LOAD;
            w_load_row_nxt = '0;
        end else if (w_accept) begin
            if (bcast || w_last_row) begin
                w_state_nxt    = S_FULL;
                w_load_row_nxt = '0;
            end else begin
                w_load_row_nxt = r_load_row + RW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            r_state       <= S_LOAD;
            r_load_row    <= '0;
            r_shadow_full <= 1'b0;
            r_swap_done   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_load_row    <= w_load_row_nxt;
            r_shadow_full <= (w_state_nxt == S_FULL);
            r_swap_done   <= w_swap;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the shadow storage is reset because stale weights must never leak after reset.
        if (reset) begin
            for (int r = 0; r < ROWS; r++) r_shadow[r] <= '0;
        end else if (w_accept) begin
            for (int r = 0; r < ROWS; r++) begin
                if (bcast || (r_load_row == RW'(r))) r_shadow[r] <= w_in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_active <= '0;
        end else if (w_swap) begin
            for (int r = 0; r < ROWS; r++) r_active[r*ROW_W +: ROW_W] <= r_shadow[r];
        end
    end

`ifdef WEIGHT_UPDATE_PP_ZERO_FLAG_EN
    logic [ROWS*COLS-1:0] r_zero_flag;

    // computed from shadow on the swap edge so the flags land with the new active set
    always_ff @(posedge clk) begin
        if (reset) begin
            r_zero_flag <= '1;
        end else if (w_swap) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    r_zero_flag[r*COLS+c] <= ~|r_shadow[r][c*PE_W +: PE_W];
                end
            end
        end
    end

    assign zero_flag = r_zero_flag;
`endif

    assign shadow_full = r_shadow_full;
    assign load_row    = r_load_row;
    assign swap_done   = r_swap_done;
    assign weight_pref = r_active;

endmodule

// File: tb/tb_weight_update_pp.sv
// Self-checking bench for weight_update_pp: directed steps plus random traffic against a word-array model.
module tb_weight_update_pp;

    localparam int N     = 16;
    localparam int ROWS  = 4;
    localparam int COLS  = 8;
    localparam int WG    = 3;
    localparam int RW    = ($clog2(ROWS) > 0 ? $clog2(ROWS) : 1);
    localparam int WPR   = COLS*WG;
    localparam int ROW_W = WPR*N;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       w_in_valid;
    logic                       w_in_ready;
    logic [ROW_W-1:0]           w_in_data;
    logic                       bcast;
    logic                       flush;
    logic                       swap;
    logic                       shadow_full;
    logic [RW-1:0]              load_row;
    logic                       swap_done;
    logic [ROWS*ROW_W-1:0]      weight_pref;
`ifdef WEIGHT_UPDATE_PP_ZERO_FLAG_EN
    logic [ROWS*COLS-1:0]       zero_flag;
`endif

    weight_update_pp #(.N(N), .ROWS(ROWS), .COLS(COLS), .WG(WG), .RW(RW)) dut (
        .clk         (clk),
        .reset       (reset),
        .w_in_valid  (w_in_valid),
        .w_in_ready  (w_in_ready),
        .w_in_data   (w_in_data),
        .bcast       (bcast),
        .flush       (flush),
        .swap        (swap),
        .shadow_full (shadow_full),
        .load_row    (load_row),
        .swap_done   (swap_done),
        .weight_pref (weight_pref)
`ifdef WEIGHT_UPDATE_PP_ZERO_FLAG_EN
        ,
        .zero_flag   (zero_flag)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: weight words per row, plus loading progress.
    logic [N-1:0] m_shadow [ROWS][WPR];
    logic [N-1:0] m_active [ROWS][WPR];
    bit           m_full;
    int           m_row;
    bit           m_done;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            for (int r = 0; r < ROWS; r++)
                for (int w = 0; w < WPR; w++) begin
                    m_shadow[r][w] = '0;
                    m_active[r][w] = '0;
                end
            m_full = 0; m_row = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (flush) begin
                m_full = 0; m_row = 0;
            end else if (swap && m_full) begin
                for (int r = 0; r < ROWS; r++)
                    for (int w = 0; w < WPR; w++) m_active[r][w] = m_shadow[r][w];
                m_full = 0; m_row = 0; m_done = 1;
            end else if (w_in_valid && !m_full) begin
                for (int r = 0; r < ROWS; r++)
                    if (bcast || r == m_row)
                        for (int w = 0; w < WPR; w++) m_shadow[r][w] = w_in_data[w*N +: N];
                if (bcast || m_row == ROWS-1) begin
                    m_full = 1; m_row = 0;
                end else begin
                    m_row++;
                end
            end
        end
    endtask

    function automatic logic [ROW_W-1:0] exp_row(input int r);
        logic [ROW_W-1:0] v;
        for (int w = 0; w < WPR; w++) v[w*N +: N] = m_active[r][w];
        return v;
    endfunction

    function automatic logic [ROWS*COLS-1:0] exp_zero();
        logic [ROWS*COLS-1:0] z;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                z[r*COLS+c] = 1'b1;
                for (int g = 0; g < WG; g++)
                    if (m_active[r][c*WG+g] != '0) z[r*COLS+c] = 1'b0;
            end
        return z;
    endfunction

    function automatic logic [ROW_W-1:0] fill_row(input logic [N-1:0] word);
        logic [ROW_W-1:0] v;
        for (int w = 0; w < WPR; w++) v[w*N +: N] = word;
        return v;
    endfunction

    function automatic logic [ROW_W-1:0] rand_row();
        logic [ROW_W-1:0] v;
        for (int w = 0; w < WPR; w++) v[w*N +: N] = N'($urandom());
        return v;
    endfunction

    task automatic check_all(input string tag);
        check($sformatf("%s.ready", tag), 512'(w_in_ready), 512'(!m_full));
        check($sformatf("%s.full", tag), 512'(shadow_full), 512'(m_full));
        check($sformatf("%s.load_row", tag), 512'(load_row), 512'(m_row));
        check($sformatf("%s.swap_done", tag), 512'(swap_done), 512'(m_done));
        for (int r = 0; r < ROWS; r++)
            check($sformatf("%s.pref_row%0d", tag, r), 512'(weight_pref[r*ROW_W +: ROW_W]), 512'(exp_row(r)));
`ifdef WEIGHT_UPDATE_PP_ZERO_FLAG_EN
        check($sformatf("%s.zero_flag", tag), 512'(zero_flag), 512'(exp_zero()));
`endif
    endtask

    // One clock edge: the model consumes the same inputs the DUT sees, then outputs are compared.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        w_in_valid = 0; bcast = 0; flush = 0; swap = 0; reset = 0;
    endtask

    task automatic beat(input string tag, input logic [ROW_W-1:0] data, input logic bc);
        w_in_valid = 1; w_in_data = data; bcast = bc;
        cycle(tag);
        w_in_valid = 0; bcast = 0;
    endtask

    task automatic do_swap(input string tag);
        swap = 1;
        cycle(tag);
        swap = 0;
    endtask

    initial begin
        idle();
        w_in_data = '0;
        reset = 1;

        // reset state
        cycle("reset0");
        cycle("reset1");
        reset = 0;
        check("reset.pref_all_zero", 512'(|weight_pref), 512'(0));
        check("reset.ready", 512'(w_in_ready), 512'(1));

        // four row beats, then swap
        for (int r = 0; r < ROWS; r++) beat($sformatf("load_beat%0d", r), fill_row(16'h0101 * 16'(r+1)), 1'b0);
        check("load.full_const", 512'(shadow_full), 512'(1));
        check("load.ready_const", 512'(w_in_ready), 512'(0));
        cycle("full_wait");
        do_swap("swap1");
        check("swap1.row3_const", 512'(weight_pref[3*ROW_W +: N]), 512'(16'h0404));
        cycle("swap1_after");

        // swap while loading is ignored
        beat("ign_b0", rand_row(), 1'b0);
        beat("ign_b1", rand_row(), 1'b0);
        do_swap("ign_swap");
        check("ign.load_row_const", 512'(load_row), 512'(2));
        check("ign.swap_done_const", 512'(swap_done), 512'(0));
        beat("ign_b2", rand_row(), 1'b0);
        beat("ign_b3", rand_row(), 1'b0);
        do_swap("ign_swap_full");

        // broadcast beat from mid-load
        beat("bc_b0", rand_row(), 1'b0);
        beat("bc_beat", fill_row(16'hA5A5), 1'b1);
        do_swap("bc_swap");
        check("bc.row0_const", 512'(weight_pref[0 +: ROW_W]), 512'(fill_row(16'hA5A5)));

        // flush partial load, including a beat dropped in the flush cycle
        for (int r = 0; r < 3; r++) beat($sformatf("fl_b%0d", r), rand_row(), 1'b0);
        flush = 1; w_in_valid = 1; w_in_data = rand_row();
        cycle("flush_partial");
        idle();
        for (int r = 0; r < ROWS; r++) beat($sformatf("fl_fresh%0d", r), rand_row(), 1'b0);
        do_swap("fl_swap");

        // flush together with swap in FULL
        for (int r = 0; r < ROWS; r++) beat($sformatf("fs_b%0d", r), rand_row(), 1'b0);
        flush = 1; swap = 1;
        cycle("flush_swap");
        idle();
        check("flush_swap.done_const", 512'(swap_done), 512'(0));
        cycle("flush_swap_after");

        // back-to-back: load starts the cycle after a swap
        for (int r = 0; r < ROWS; r++) beat($sformatf("bb_b%0d", r), rand_row(), 1'b0);
        do_swap("bb_swap");
        beat("bb_next", rand_row(), 1'b0);

        // reset in FULL and mid-load
        for (int r = 1; r < ROWS; r++) beat($sformatf("rf_b%0d", r), rand_row(), 1'b0);
        reset = 1; swap = 1;
        cycle("reset_full");
        idle();
        check("reset_full.pref_const", 512'(|weight_pref), 512'(0));
        beat("rm_b0", rand_row(), 1'b0);
        beat("rm_b1", rand_row(), 1'b0);
        reset = 1; w_in_valid = 1; w_in_data = rand_row();
        cycle("reset_mid");
        idle();
        check("reset_mid.load_row_const", 512'(load_row), 512'(0));

        // random traffic
        for (int i = 0; i < 300; i++) begin
            reset      = ($urandom_range(0, 79) == 0);
            w_in_valid = 1'($urandom_range(0, 1));
            bcast      = ($urandom_range(0, 7) == 0);
            flush      = ($urandom_range(0, 15) == 0);
            swap       = ($urandom_range(0, 2) == 0);
            w_in_data  = rand_row();
            cycle($sformatf("rnd%0d", i));
        end
        idle();
        cycle("rnd_end");

`ifdef WEIGHT_UPDATE_PP_ZERO_FLAG_EN
        // PE(0,0) and PE(3,7) all zero, every other PE non-zero
        flush = 1;
        cycle("zf_flush");
        idle();
        for (int r = 0; r < ROWS; r++) begin
            logic [ROW_W-1:0] d;
            for (int w = 0; w < WPR; w++) d[w*N +: N] = N'($urandom()) | N'(1);
            if (r == 0) d[0 +: WG*N] = '0;
            if (r == 3) d[7*WG*N +: WG*N] = '0;
            beat($sformatf("zf_b%0d", r), d, 1'b0);
        end
        do_swap("zf_swap");
        check("zf.const", 512'(zero_flag), 512'(32'h8000_0001));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
